// File: rtl/fir_root_stream.sv
// fir_root_stream: streaming TAPS-tap direct-form FIR, saturated to OW bits,
// followed by a sequential restoring integer square root (one root bit/cycle).
// Ports:
//   clk, Rst                 clock, async active-high reset
//   in_valid/in_ready/Data_i input sample handshake
//   coef_we/addr/data        runtime coefficient write port
//   out_valid/out_ready      result handshake
//   FIRout/FIRsat            saturated FIR result and clamp flag
//   ROOTout/ROOTrem          floor(sqrt(FIRout)) and remainder
module fir_root_stream #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int TAPS  = 7,
  parameter int OW    = 8,
  parameter int SHIFT = 0,
  localparam int AW   = $clog2(TAPS),
  localparam int N    = OW / 2
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] Data_i,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] FIRout,
  output logic          FIRsat,
  output logic [N-1:0]  ROOTout,
  output logic [N:0]    ROOTrem
);

  localparam int ACC  = DW + CW + AW;
  localparam int PW   = DW + CW;
  localparam int CNTW = $clog2(N) + 1;

  localparam logic [ACC-1:0] MAXV =
    {{(ACC-OW){1'b0}}, {OW{1'b1}}};
  localparam logic [AW:0] TAPS_L = (AW+1)'(TAPS);
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILT,
    ROOT,
    HOLD
  } state_t;

  state_t state;

  logic [DW-1:0] x [TAPS];
  logic [CW-1:0] c [TAPS];

  logic [OW-1:0]   rad;
  logic [N:0]      rem;
  logic [N-1:0]    root;
  logic [CNTW-1:0] cnt;
  logic [OW-1:0]   fir_q;
  logic            sat_q;

  logic            accept;
  logic [ACC-1:0]  acc;
  logic [ACC-1:0]  sh;
  logic [OW-1:0]   fir_d;
  logic            sat_d;

  logic [N+2:0]    rem_t;
  logic [N+2:0]    trial;
  logic            ge;
  logic [N+2:0]    rem_w;
  logic [N:0]      rem_n;
  logic [N:0]      root_w;
  logic [N-1:0]    root_n;

  assign in_ready = (state == IDLE) ||
                    ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    logic [PW-1:0] p;
    acc = '0;
    p   = '0;
    for (int i = 0; i < TAPS; i++) begin
      p   = PW'(x[i]) * PW'(c[i]);
      acc = acc + {{AW{1'b0}}, p};
    end
    sh    = acc >> SHIFT;
    sat_d = (sh > MAXV);
    fir_d = sat_d ? {OW{1'b1}} : sh[OW-1:0];
  end

  // Restoring step: bring down the next two radicand bits and
  // try to subtract 4*root+1.
  always_comb begin
    rem_t  = {rem, rad[OW-1 -: 2]};
    trial  = {1'b0, root, 2'b01};
    ge     = (rem_t >= trial);
    rem_w  = ge ? (rem_t - trial) : rem_t;
    rem_n  = rem_w[N:0];
    root_w = {root, ge};
    root_n = root_w[N-1:0];
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
      c[0]      <= CW'(1);
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      cnt       <= '0;
      fir_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      FIRout    <= '0;
      FIRsat    <= 1'b0;
      ROOTout   <= '0;
      ROOTrem   <= '0;
    end else begin
      if (coef_we && ({1'b0, coef_addr} < TAPS_L))
        c[coef_addr] <= coef_data;

      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--)
          x[i] <= x[i-1];
        x[0] <= Data_i;
      end

      unique case (state)
        IDLE: begin
          if (in_valid)
            state <= FILT;
        end
        FILT: begin
          fir_q <= fir_d;
          sat_q <= sat_d;
          rad   <= fir_d;
          rem   <= '0;
          root  <= '0;
          cnt   <= '0;
          state <= ROOT;
        end
        ROOT: begin
          rad  <= rad << 2;
          rem  <= rem_n;
          root <= root_n;
          cnt  <= cnt + CNTW'(1);
          if (cnt == LAST) begin
            FIRout    <= fir_q;
            FIRsat    <= sat_q;
            ROOTout   <= root_n;
            ROOTrem   <= rem_n;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? FILT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_root_stream.sv
// tb_fir_root_stream: directed + randomized bench for fir_root_stream
// against a sample-level model (history, coefficients, integer sqrt).
module tb_fir_root_stream;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int TAPS  = 7;
  localparam int OW    = 8;
  localparam int SHIFT = 0;
  localparam int AW    = $clog2(TAPS);
  localparam int N     = OW / 2;

  logic          clk = 1'b0;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] Data_i;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] FIRout;
  logic          FIRsat;
  logic [N-1:0]  ROOTout;
  logic [N:0]    ROOTrem;

  always #5 clk = ~clk;

  fir_root_stream #(
    .DW(DW), .CW(CW), .TAPS(TAPS),
    .OW(OW), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Data_i(Data_i),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .FIRout(FIRout),
    .FIRsat(FIRsat),
    .ROOTout(ROOTout),
    .ROOTrem(ROOTrem)
  );

  typedef struct {
    int fir;
    int sat;
    int root;
    int rem;
  } res_t;

  res_t q[$];
  res_t last;
  int   mx [TAPS];
  int   mc [TAPS];
  int   compared   = 0;
  int   mismatched = 0;
  int   wait_cnt   = 0;
  bit   seen       = 1'b1;

  function automatic void check(string name, int got, int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, got, exp, $time);
    end
  endfunction

  function automatic void flag(string name);
    compared++;
    mismatched++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  function automatic res_t model_eval();
    res_t r;
    int   a;
    int   s;
    int   rt;
    a = 0;
    for (int i = 0; i < TAPS; i++)
      a += mc[i] * mx[i];
    s = a >>> SHIFT;
    if (s > (1 << OW) - 1) begin
      r.fir = (1 << OW) - 1;
      r.sat = 1;
    end else begin
      r.fir = s;
      r.sat = 0;
    end
    rt = 0;
    while ((rt + 1) * (rt + 1) <= r.fir)
      rt++;
    r.root = rt;
    r.rem  = r.fir - rt * rt;
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end
    mc[0] = 1;
    q.delete();
    last  = '{0, 0, 0, 0};
    seen  = 1'b1;
  endfunction

  function automatic void cmp_out(res_t e);
    check("FIRout",  int'(FIRout),  e.fir);
    check("FIRsat",  int'(FIRsat),  e.sat);
    check("ROOTout", int'(ROOTout), e.root);
    check("ROOTrem", int'(ROOTrem), e.rem);
  endfunction

  always @(negedge clk) begin
    if (!Rst) begin
      if (out_valid)
        check("in_ready", int'(in_ready), int'(out_ready));
      else
        check("in_ready", int'(in_ready), (q.size() == 0) ? 1 : 0);

      if (q.size() > 0 && !seen) begin
        wait_cnt++;
        if (out_valid) begin
          seen = 1'b1;
          check("latency", wait_cnt, N + 2);
        end else if (wait_cnt > N + 8) begin
          flag("timeout waiting for out_valid");
          void'(q.pop_front());
          seen = 1'b1;
        end
      end

      if (out_valid) begin
        if (q.size() == 0) begin
          flag("spurious out_valid");
        end else begin
          cmp_out(q[0]);
          if (out_ready)
            last = q.pop_front();
        end
      end else begin
        cmp_out(last);
      end

      if (coef_we && int'(coef_addr) < TAPS)
        mc[coef_addr] = int'(coef_data);

      if (in_valid && in_ready) begin
        for (int i = TAPS - 1; i > 0; i--)
          mx[i] = mx[i-1];
        mx[0] = int'(Data_i);
        q.push_back(model_eval());
        wait_cnt = 0;
        seen     = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(d);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic send(input int d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    Data_i   = DW'(d);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok)
      flag("send not accepted");
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid)
        ok = 1'b1;
      else
        tick();
    end
    if (!ok)
      flag("wait_valid timeout");
  endtask

  task automatic expect_res(string tag, int f, int s, int r, int m);
    check({tag, ".FIRout"},  int'(FIRout),  f);
    check({tag, ".FIRsat"},  int'(FIRsat),  s);
    check({tag, ".ROOTout"}, int'(ROOTout), r);
    check({tag, ".ROOTrem"}, int'(ROOTrem), m);
  endtask

  initial begin
    bit taken;
    Rst       = 1'b1;
    in_valid  = 1'b0;
    Data_i    = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    Rst = 1'b0;
    tick();

    check("reset.out_valid", int'(out_valid), 0);
    check("reset.in_ready",  int'(in_ready),  1);
    expect_res("reset", 0, 0, 0, 0);

    // 1: pass-through default coefficients
    send(200);
    wait_valid();
    expect_res("t1", 200, 0, 14, 4);
    out_ready = 1'b1;
    tick();

    // 2: moving sum of seven 10s
    for (int i = 0; i < TAPS; i++)
      wr_coef(i, 1);
    for (int k = 0; k < TAPS; k++) begin
      send(10);
      wait_valid();
      if (k == TAPS - 1)
        expect_res("t2", 70, 0, 8, 6);
      tick();
    end

    // 3: saturation
    for (int i = 0; i < TAPS; i++)
      wr_coef(i, 255);
    send(255);
    wait_valid();
    expect_res("t3", 255, 1, 15, 30);
    tick();

    // 4: backpressure in HOLD, then consume + accept on one edge
    out_ready = 1'b0;
    send(255);
    wait_valid();
    repeat (10) tick();
    check("t4.in_ready_hold", int'(in_ready), 0);
    in_valid  = 1'b1;
    Data_i    = DW'(1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t4.in_ready_go", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("t4.valid_drop", int'(out_valid), 0);
    check("t4.busy",       int'(in_ready),  0);
    wait_valid();
    tick();

    // 5: reset in the middle of ROOT
    send(100);
    repeat (3) tick();
    #2;
    Rst = 1'b1;
    model_reset();
    #1;
    check("t5.out_valid", int'(out_valid), 0);
    expect_res("t5.rst", 0, 0, 0, 0);
    tick();
    Rst = 1'b0;
    tick();
    send(49);
    wait_valid();
    expect_res("t5", 49, 0, 7, 0);
    tick();

    // 6: out-of-range write, and a write landing on the FILT edge
    wr_coef(7, 99);
    in_valid = 1'b1;
    Data_i   = DW'(30);
    tick();
    in_valid  = 1'b0;
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = CW'(2);
    tick();
    coef_we = 1'b0;
    wait_valid();
    expect_res("t6a", 30, 0, 5, 5);
    tick();
    send(20);
    wait_valid();
    expect_res("t6b", 40, 0, 6, 4);
    tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      taken = in_valid && in_ready;
      tick();
      if (!in_valid || taken) begin
        in_valid = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 1) == 1)
          Data_i = DW'($urandom_range(0, 255));
        else
          Data_i = DW'($urandom_range(0, 40));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      coef_we   = ($urandom_range(0, 9) == 0);
      coef_addr = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 3) == 0)
        coef_data = CW'($urandom_range(0, 255));
      else
        coef_data = CW'($urandom_range(0, 3));
    end
    coef_we   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
